// File: rtl/truth_table_checker.sv
// Rebuilds a 4-input truth table from (a,b,c,d,f) samples and compares it
// against EXPECTED_TT, reporting pass, mismatch mask, error count and first error.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      one-cycle pulse: clear and begin collection
//   sample_valid, a,b,c,d, f   one observed sample, index {a,b,c,d}
//   busy, done, pass           status (pass valid while done)
//   timeout, conflict          sample budget exhausted / inconsistent repeat
//   captured_tt, covered       rebuilt table and coverage map
//   mismatch_mask, err_count,  covered differences, their count,
//   first_err_idx              and the lowest failing minterm
module truth_table_checker #(
  parameter logic [15:0] EXPECTED_TT = 16'h0000,
  parameter int          MAX_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sample_valid,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        f,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        conflict,
  output logic [15:0] captured_tt,
  output logic [15:0] covered,
  output logic [15:0] mismatch_mask,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  count;

  logic [3:0]  idx;
  logic [15:0] hit;
  logic [15:0] cov_next;
  logic [7:0]  cnt_next;
  logic [15:0] mm_calc;
  logic [4:0]  pop_calc;
  logic [3:0]  first_calc;

  assign idx      = {a, b, c, d};
  assign hit      = 16'h0001 << idx;
  assign cov_next = covered | hit;
  assign cnt_next = count + 8'd1;

  // Uncovered minterms never count as errors.
  assign mm_calc  = (captured_tt ^ EXPECTED_TT) & covered;

  always_comb begin
    pop_calc = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop_calc = pop_calc + {4'd0, mm_calc[i]};
    end
  end

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    first_calc = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mm_calc[i]) begin
        first_calc = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      conflict      <= 1'b0;
      captured_tt   <= 16'h0000;
      covered       <= 16'h0000;
      mismatch_mask <= 16'h0000;
      err_count     <= 5'd0;
      first_err_idx <= 4'd0;
    end else if (start) begin
      state         <= COLLECT;
      count         <= 8'd0;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      conflict      <= 1'b0;
      captured_tt   <= 16'h0000;
      covered       <= 16'h0000;
      mismatch_mask <= 16'h0000;
      err_count     <= 5'd0;
      first_err_idx <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        COLLECT: begin
          if (sample_valid) begin
            if (!covered[idx]) begin
              captured_tt[idx] <= f;
            end else if (captured_tt[idx] != f) begin
              conflict <= 1'b1;
            end
            covered <= cov_next;
            count   <= cnt_next;
            // Completing coverage wins over an expiring budget.
            if (cov_next == 16'hFFFF) begin
              state <= CHECK;
            end else if (cnt_next == 8'(MAX_SAMPLES)) begin
              timeout <= 1'b1;
              state   <= CHECK;
            end
          end
        end
        CHECK: begin
          mismatch_mask <= mm_calc;
          err_count     <= pop_calc;
          first_err_idx <= first_calc;
          busy          <= 1'b0;
          state         <= DONE;
        end
        DONE: begin
          done <= 1'b1;
          pass <= (mismatch_mask == 16'h0000) & ~conflict & ~timeout;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: directed table vectors,
// corner-case sequences and randomized runs against a per-minterm model.
module tb_truth_table_checker;

  localparam logic [15:0] EXP = 16'hA5C3;
  localparam int          MAXS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, f = 1'b0;
  logic        busy, done, pass, timeout, conflict;
  logic [15:0] captured_tt, covered, mismatch_mask;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;

  int total = 0;
  int bad = 0;

  truth_table_checker #(.EXPECTED_TT(EXP), .MAX_SAMPLES(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sample_valid(sample_valid),
    .a(a), .b(b), .c(c), .d(d), .f(f),
    .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .conflict(conflict),
    .captured_tt(captured_tt), .covered(covered),
    .mismatch_mask(mismatch_mask),
    .err_count(err_count),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tt;
    logic [15:0] mm;
    logic [4:0]  err;
    logic [3:0]  first;
    logic        pass;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {2'b00, busy, done, pass, timeout, conflict,
            captured_tt, covered, mismatch_mask,
            err_count, first_err_idx};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    sample_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one sample at a negedge, returns just after the accepting posedge.
  task automatic send(input int i, input logic fv);
    logic [3:0] v;
    v = 4'(i);
    @(negedge clk);
    sample_valid = 1'b1;
    {a, b, c, d} = v;
    f = fv;
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Counts negedges from the last accepting edge until done rises.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("done_wait_expired", 64'(done), 64'd1);
  endtask

  task automatic send_tt(input logic [15:0] tt);
    for (int i = 0; i < 16; i++) send(i, tt[i]);
  endtask

  initial begin
    int lat;
    logic [15:0] exp_tt;
    exp_tt = EXP;

    vt[0] = '{tt: 16'hA5C3,          mm: 16'h0000, err: 5'd0,  first: 4'd0,  pass: 1'b1};
    vt[1] = '{tt: 16'hA5C3 ^ 16'h0220, mm: 16'h0220, err: 5'd2,  first: 4'd5,  pass: 1'b0};
    vt[2] = '{tt: 16'hA5C3 ^ 16'h8000, mm: 16'h8000, err: 5'd1,  first: 4'd15, pass: 1'b0};
    vt[3] = '{tt: ~16'hA5C3,         mm: 16'hFFFF, err: 5'd16, first: 4'd0,  pass: 1'b0};
    vt[4] = '{tt: 16'hA5C3 ^ 16'h1001, mm: 16'h1001, err: 5'd2,  first: 4'd0,  pass: 1'b0};

    // Reset with random inputs driven
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'($urandom);
      sample_valid = 1'($urandom);
      {a, b, c, d, f} = 5'($urandom);
    end
    chk("reset_outputs", all_out(), 64'd0);
    @(negedge clk);
    start = 1'b0;
    sample_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_outputs", all_out(), 64'd0);

    // Sample in IDLE is ignored
    send(4, 1'b1);
    idle_cycle();
    chk("idle_sample_ignored", 64'(covered), 64'd0);

    // Table-driven full sweeps
    for (int t = 0; t < 5; t++) begin
      pulse_start();
      chk($sformatf("v%0d_busy", t), 64'(busy), 64'd1);
      send_tt(vt[t].tt);
      wait_done(lat);
      chk($sformatf("v%0d_latency", t), 64'(lat), 64'd3);
      chk($sformatf("v%0d_pass", t), 64'(pass), 64'(vt[t].pass));
      chk($sformatf("v%0d_tt", t), 64'(captured_tt), 64'(vt[t].tt));
      chk($sformatf("v%0d_cov", t), 64'(covered), 64'hFFFF);
      chk($sformatf("v%0d_mm", t), 64'(mismatch_mask), 64'(vt[t].mm));
      chk($sformatf("v%0d_err", t), 64'(err_count), 64'(vt[t].err));
      chk($sformatf("v%0d_first", t), 64'(first_err_idx), 64'(vt[t].first));
      chk($sformatf("v%0d_flags", t), 64'({busy, timeout, conflict}), 64'd0);
    end

    // Sample in DONE is ignored
    send(5, ~exp_tt[5]);
    idle_cycle();
    chk("done_sample_ignored", 64'({done, captured_tt}), 64'({1'b1, ~16'hA5C3 ^ 16'h1001 ^ ~16'h1001 ^ 16'h1001}) & 64'h1FFFF | 64'(1'b0));

    // start + sample_valid in the same cycle: sample dropped
    @(negedge clk);
    start = 1'b1;
    sample_valid = 1'b1;
    {a, b, c, d} = 4'd0;
    f = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sample_valid = 1'b0;
    chk("start_drops_sample", 64'({done, busy, covered}), 64'({1'b0, 1'b1, 16'h0000}));

    // Conflict: idx 3 resent with opposite value before completion
    pulse_start();
    for (int i = 0; i < 15; i++) send(i, exp_tt[i]);
    send(3, ~exp_tt[3]);
    send(15, exp_tt[15]);
    wait_done(lat);
    chk("conf_flag", 64'(conflict), 64'd1);
    chk("conf_pass", 64'(pass), 64'd0);
    chk("conf_mm", 64'(mismatch_mask), 64'd0);
    chk("conf_tt_kept", 64'(captured_tt), 64'hA5C3);

    // Timeout: only idx 0..14 for MAXS samples
    pulse_start();
    for (int k = 0; k < MAXS - 1; k++) send(k % 15, exp_tt[k % 15]);
    idle_cycle();
    chk("tmo_not_yet", 64'({busy, timeout}), 64'({1'b1, 1'b0}));
    send((MAXS - 1) % 15, exp_tt[(MAXS - 1) % 15]);
    wait_done(lat);
    chk("tmo_flag", 64'(timeout), 64'd1);
    chk("tmo_cov", 64'(covered), 64'h7FFF);
    chk("tmo_pass", 64'(pass), 64'd0);
    chk("tmo_latency", 64'(lat), 64'd3);

    // Coverage completing on the last budgeted sample wins
    pulse_start();
    for (int k = 0; k < MAXS - 1; k++) send(k % 15, exp_tt[k % 15]);
    send(15, exp_tt[15]);
    wait_done(lat);
    chk("cov_wins_tmo", 64'(timeout), 64'd0);
    chk("cov_wins_pass", 64'(pass), 64'd1);

    // Async reset mid-collection
    pulse_start();
    for (int i = 0; i < 8; i++) send(i, exp_tt[i]);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", all_out(), 64'd0);
    @(negedge clk);
    sample_valid = 1'b0;
    rst_n = 1'b1;
    pulse_start();
    send_tt(EXP);
    wait_done(lat);
    chk("post_reset_pass", 64'({done, pass}), 64'd3);
    pulse_start();
    chk("start_clears_done", 64'({done, busy}), 64'({1'b0, 1'b1}));

    // Randomized runs against a per-minterm model
    for (int r = 0; r < 30; r++) begin
      bit          seen[16];
      bit          val[16];
      int          cnt, nseen;
      bit          conf, tmo, fin;
      logic [15:0] emm, ett, ecov;
      int          eerr, efirst;
      for (int i = 0; i < 16; i++) begin
        seen[i] = 0;
        val[i] = 0;
      end
      cnt = 0; conf = 0; tmo = 0; fin = 0;
      if (r > 0) pulse_start();
      while (!fin) begin
        int  i;
        bit  fv;
        i = (r % 5 == 4) ? $urandom_range(0, 14) : $urandom_range(0, 15);
        fv = exp_tt[i] ^ ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send(i, fv);
        if (!seen[i]) begin
          seen[i] = 1;
          val[i] = fv;
        end else if (val[i] != fv) begin
          conf = 1;
        end
        cnt++;
        nseen = 0;
        for (int j = 0; j < 16; j++) nseen += seen[j];
        if (nseen == 16) fin = 1;
        else if (cnt == MAXS) begin
          tmo = 1;
          fin = 1;
        end
      end
      wait_done(lat);
      emm = 0; ett = 0; ecov = 0; eerr = 0; efirst = -1;
      for (int j = 0; j < 16; j++) begin
        ecov[j] = seen[j];
        ett[j] = seen[j] & val[j];
        if (seen[j] && val[j] != exp_tt[j]) begin
          emm[j] = 1;
          eerr++;
          if (efirst < 0) efirst = j;
        end
      end
      if (efirst < 0) efirst = 0;
      chk($sformatf("r%0d_state", r),
          64'({done, timeout, conflict, pass}),
          64'({1'b1, tmo, conf, (eerr == 0) && !conf && !tmo}));
      chk($sformatf("r%0d_tables", r),
          {16'd0, captured_tt, covered, mismatch_mask},
          {16'd0, ett, ecov, emm});
      chk($sformatf("r%0d_err", r),
          64'({err_count, first_err_idx}),
          64'({5'(eerr), 4'(efirst)}));
      // restart for next run comes through pulse_start
      if (r == 0) pulse_start();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
